// File: rtl/fpu_tag_pkg.sv
// Shared definitions for the 8087 tag word: tag encodings, stack command
// opcodes, controller states and a field-replace helper.
package fpu_tag_pkg;

  localparam logic [1:0] TAG_VALID   = 2'b00;
  localparam logic [1:0] TAG_ZERO    = 2'b01;
  localparam logic [1:0] TAG_SPECIAL = 2'b10;
  localparam logic [1:0] TAG_EMPTY   = 2'b11;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_PUSH     = 3'd1,
    OP_POP      = 3'd2,
    OP_POP2     = 3'd3,
    OP_WRITE_ST = 3'd4,
    OP_FREE     = 3'd5,
    OP_LOAD     = 3'd6,
    OP_CLEAR    = 3'd7
  } tag_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CLASSIFY = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_COMMIT2  = 2'd3
  } tag_state_e;

  // Replace the 2-bit ST(idx) field of a tag word.
  function automatic logic [15:0] set_field(input logic [15:0] word,
                                            input logic [2:0]  idx,
                                            input logic [1:0]  tag);
    logic [15:0] res;
    res = word;
    res[{idx, 1'b0} +: 2] = tag;
    return res;
  endfunction

endpackage

// File: rtl/fpu_tag_classify.sv
// Combinational 80-bit extended-precision operand classifier producing the
// 2-bit tag (valid / zero / special). Shared with the status/FXAM logic.
module fpu_tag_classify (
  input  logic [79:0] value,
  output logic [1:0]  tag
);
  import fpu_tag_pkg::*;

  logic [14:0] exp_s;
  logic [63:0] man_s;
  logic        unused_sign_s;

  assign exp_s         = value[78:64];
  assign man_s         = value[63:0];
  assign unused_sign_s = value[79];

  // Zero first, then NaN/inf, denormal and unnormal all map to special.
  always_comb begin
    tag = TAG_VALID;
    if ((exp_s == 15'd0) && (man_s == 64'd0)) begin
      tag = TAG_ZERO;
    end else if (exp_s == 15'h7FFF) begin
      tag = TAG_SPECIAL;
    end else if (exp_s == 15'd0) begin
      tag = TAG_SPECIAL;
    end else if (!man_s[63]) begin
      tag = TAG_SPECIAL;
    end else begin
      tag = TAG_VALID;
    end
  end

endmodule

// File: rtl/fpu_tag_update_ctrl.sv
// Tag-word write controller: accepts stack commands, classifies operands and
// issues one registered write per step to the tag storage, flagging stack faults.
module fpu_tag_update_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [2:0]  cmd_index,
  input  logic [79:0] cmd_value,
  input  logic [15:0] cmd_tagword,
  input  logic [15:0] tag_in,
  output logic [15:0] tag_write_data,
  output logic        tag_write_enable,
  output logic        done,
  output logic        stack_overflow,
  output logic        stack_underflow
);
  import fpu_tag_pkg::*;

  tag_state_e  state_r, state_s;
  tag_op_e     op_r;
  tag_op_e     cmd_op_s;
  logic [2:0]  index_r;
  logic [79:0] value_r;
  logic        udf_pend_r, udf_pend_s;
  logic [1:0]  cls_s;
  logic [15:0] data_s;
  logic        we_s, done_s, ovf_s, udf_s;
  logic        accept_s;

  assign cmd_op_s  = tag_op_e'(cmd_op);
  assign cmd_ready = (state_r == ST_IDLE);
  assign accept_s  = cmd_valid && (state_r == ST_IDLE);

  fpu_tag_classify u_classify (
    .value (value_r),
    .tag   (cls_s)
  );

  // Next state and the write/flag values that get registered onto the outputs.
  // Outputs are computed one cycle ahead so the strobe is visible in COMMIT/COMMIT2.
  always_comb begin
    state_s    = state_r;
    data_s     = tag_write_data;
    we_s       = 1'b0;
    done_s     = 1'b0;
    ovf_s      = 1'b0;
    udf_s      = 1'b0;
    udf_pend_s = udf_pend_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (cmd_op_s)
            OP_NOP: begin
              state_s = ST_COMMIT;
              done_s  = 1'b1;
            end
            OP_PUSH, OP_WRITE_ST: begin
              state_s = ST_CLASSIFY;
            end
            OP_POP: begin
              state_s = ST_COMMIT;
              we_s    = 1'b1;
              done_s  = 1'b1;
              data_s  = {TAG_EMPTY, tag_in[15:2]};
              udf_s   = (tag_in[1:0] == TAG_EMPTY);
            end
            OP_POP2: begin
              state_s    = ST_COMMIT;
              we_s       = 1'b1;
              data_s     = {TAG_EMPTY, tag_in[15:2]};
              udf_pend_s = (tag_in[1:0] == TAG_EMPTY);
            end
            OP_FREE: begin
              state_s = ST_COMMIT;
              we_s    = 1'b1;
              done_s  = 1'b1;
              data_s  = set_field(tag_in, cmd_index, TAG_EMPTY);
            end
            OP_LOAD: begin
              state_s = ST_COMMIT;
              we_s    = 1'b1;
              done_s  = 1'b1;
              data_s  = cmd_tagword;
            end
            OP_CLEAR: begin
              state_s = ST_COMMIT;
              we_s    = 1'b1;
              done_s  = 1'b1;
              data_s  = 16'hFFFF;
            end
            default: begin
              state_s = ST_IDLE;
            end
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLASSIFY: begin
        state_s = ST_COMMIT;
        we_s    = 1'b1;
        done_s  = 1'b1;
        if (op_r == OP_PUSH) begin
          // A push into a non-empty ST(7) still happens but stores indefinite.
          ovf_s  = (tag_in[15:14] != TAG_EMPTY);
          data_s = {tag_in[13:0], ovf_s ? TAG_SPECIAL : cls_s};
        end else begin
          data_s = set_field(tag_in, index_r, cls_s);
        end
      end
      ST_COMMIT: begin
        if (op_r == OP_POP2) begin
          state_s = ST_COMMIT2;
          we_s    = 1'b1;
          done_s  = 1'b1;
          data_s  = {TAG_EMPTY, tag_write_data[15:2]};
          udf_s   = udf_pend_r || (tag_write_data[1:0] == TAG_EMPTY);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_COMMIT2: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, latched command fields and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r          <= ST_IDLE;
      op_r             <= OP_NOP;
      index_r          <= 3'd0;
      value_r          <= 80'd0;
      udf_pend_r       <= 1'b0;
      tag_write_data   <= 16'hFFFF;
      tag_write_enable <= 1'b0;
      done             <= 1'b0;
      stack_overflow   <= 1'b0;
      stack_underflow  <= 1'b0;
    end else begin
      state_r          <= state_s;
      udf_pend_r       <= udf_pend_s;
      tag_write_data   <= data_s;
      tag_write_enable <= we_s;
      done             <= done_s;
      stack_overflow   <= ovf_s;
      stack_underflow  <= udf_s;
      if (accept_s) begin
        op_r    <= cmd_op_s;
        index_r <= cmd_index;
        value_r <= cmd_value;
      end
    end
  end

endmodule

// File: tb/tb_fpu_tag_update_ctrl.sv
// Directed bench for fpu_tag_update_ctrl with a stack-level reference model
// and a bench-side tag storage that follows the write strobe.
module tb_fpu_tag_update_ctrl;

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, POP2 = 3'd3,
                         WST = 3'd4, FREE = 3'd5, LOAD = 3'd6, CLEAR = 3'd7;

  localparam logic [79:0] V_ONE   = {1'b0, 15'h3FFF, 64'h8000_0000_0000_0000};
  localparam logic [79:0] V_ZERO  = 80'd0;
  localparam logic [79:0] V_NAN   = {1'b0, 15'h7FFF, 64'hC000_0000_0000_0000};
  localparam logic [79:0] V_DENOR = {1'b0, 15'h0000, 64'h0000_0000_0000_0001};
  localparam logic [79:0] V_UNNOR = {1'b0, 15'h4000, 64'h4000_0000_0000_0000};

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_index;
  logic [79:0] cmd_value;
  logic [15:0] cmd_tagword;
  logic [15:0] tag_in;
  logic [15:0] tag_write_data;
  logic        tag_write_enable;
  logic        done;
  logic        stack_overflow;
  logic        stack_underflow;

  logic [15:0] store;
  logic        preload_en;
  logic [15:0] preload_val;

  logic        cmp_en;
  logic        exp_ready, exp_we, exp_done, exp_ovf, exp_udf;
  logic [15:0] exp_data;
  int          errors = 0;
  int          checks = 0;

  fpu_tag_update_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_index        (cmd_index),
    .cmd_value        (cmd_value),
    .cmd_tagword      (cmd_tagword),
    .tag_in           (tag_in),
    .tag_write_data   (tag_write_data),
    .tag_write_enable (tag_write_enable),
    .done             (done),
    .stack_overflow   (stack_overflow),
    .stack_underflow  (stack_underflow)
  );

  always #5 clk = ~clk;

  // Tag register storage as the rest of the FPU would have it.
  always @(posedge clk) begin
    if (reset) store <= 16'hFFFF;
    else if (preload_en) store <= preload_val;
    else if (tag_write_enable) store <= tag_write_data;
  end
  assign tag_in = store;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model expectation.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmd_ready", {15'd0, cmd_ready}, {15'd0, exp_ready});
      chk("write_enable", {15'd0, tag_write_enable}, {15'd0, exp_we});
      chk("write_data", tag_write_data, exp_data);
      chk("done", {15'd0, done}, {15'd0, exp_done});
      chk("overflow", {15'd0, stack_overflow}, {15'd0, exp_ovf});
      chk("underflow", {15'd0, stack_underflow}, {15'd0, exp_udf});
    end
  end

  function automatic logic [1:0] m_class(input logic [79:0] v);
    logic [14:0] e;
    logic [63:0] m;
    e = v[78:64];
    m = v[63:0];
    if (e == 15'd0 && m == 64'd0) return 2'b01;
    if (e == 15'h7FFF || e == 15'd0 || !m[63]) return 2'b10;
    return 2'b00;
  endfunction

  // Stack-level model: view the word as eight ST(i) slots and move them.
  task automatic model(input logic [15:0] w, input logic [2:0] op, input logic [2:0] idx,
                       input logic [79:0] v, input logic [15:0] tw,
                       output logic [15:0] d1, output logic [15:0] dfin,
                       output logic ovf, output logic udf);
    logic [1:0] st [8];
    for (int i = 0; i < 8; i++) st[i] = w[2*i +: 2];
    ovf = 1'b0;
    udf = 1'b0;
    d1  = w;
    case (op)
      PUSH: begin
        ovf = (st[7] != 2'b11);
        for (int i = 7; i > 0; i--) st[i] = st[i-1];
        st[0] = ovf ? 2'b10 : m_class(v);
      end
      POP, POP2: begin
        udf = (st[0] == 2'b11);
        for (int i = 0; i < 7; i++) st[i] = st[i+1];
        st[7] = 2'b11;
        if (op == POP2) begin
          for (int i = 0; i < 8; i++) d1[2*i +: 2] = st[i];
          udf = udf | (st[0] == 2'b11);
          for (int i = 0; i < 7; i++) st[i] = st[i+1];
          st[7] = 2'b11;
        end
      end
      WST:   st[idx] = m_class(v);
      FREE:  st[idx] = 2'b11;
      LOAD:  for (int i = 0; i < 8; i++) st[i] = tw[2*i +: 2];
      CLEAR: for (int i = 0; i < 8; i++) st[i] = 2'b11;
      default: ;
    endcase
    for (int i = 0; i < 8; i++) dfin[2*i +: 2] = st[i];
  endtask

  task automatic preload(input logic [15:0] val);
    preload_val = val;
    preload_en  = 1'b1;
    @(posedge clk); #1;
    preload_en  = 1'b0;
  endtask

  // Issue one command at the current cycle and track it to completion.
  task automatic run_cmd(input logic [2:0] op, input logic [2:0] idx, input logic [79:0] v,
                         input logic [15:0] tw, input logic [15:0] lit_data,
                         input logic lit_ovf, input logic lit_udf, input bit poke);
    logic [15:0] d1, dfin;
    logic        m_ovf, m_udf;
    int          last_k;
    model(store, op, idx, v, tw, d1, dfin, m_ovf, m_udf);
    last_k = (op == PUSH || op == WST || op == POP2) ? 2 : 1;
    cmd_valid = 1'b1; cmd_op = op; cmd_index = idx; cmd_value = v; cmd_tagword = tw;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (poke) begin
      cmd_valid = 1'b1;
      cmd_op    = CLEAR;
    end
    for (int k = 1; k <= last_k; k++) begin
      exp_ready = 1'b0; exp_we = 1'b0; exp_done = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0;
      if (op == POP2 && k == 1) begin
        exp_we   = 1'b1;
        exp_data = d1;
      end
      if (k == last_k) begin
        exp_we   = (op != NOP);
        if (op != NOP) exp_data = dfin;
        exp_done = 1'b1;
        exp_ovf  = m_ovf;
        exp_udf  = m_udf;
      end
      @(negedge clk);
      if (k == last_k) begin
        chk("literal_data", tag_write_data, lit_data);
        chk("literal_ovf", {15'd0, stack_overflow}, {15'd0, lit_ovf});
        chk("literal_udf", {15'd0, stack_underflow}, {15'd0, lit_udf});
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
    exp_ready = 1'b1; exp_we = 1'b0; exp_done = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = NOP; cmd_index = 3'd0;
    cmd_value = 80'd0; cmd_tagword = 16'd0; preload_en = 1'b0; preload_val = 16'd0;
    cmp_en = 1'b0;
    exp_ready = 1'b1; exp_we = 1'b0; exp_data = 16'hFFFF;
    exp_done = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    reset  = 1'b0;
    @(posedge clk); #1;

    run_cmd(PUSH,  3'd0, V_ONE,   16'd0,    16'hFFFC, 1'b0, 1'b0, 1'b0);
    run_cmd(PUSH,  3'd0, V_ZERO,  16'd0,    16'hFFF1, 1'b0, 1'b0, 1'b0);
    run_cmd(PUSH,  3'd0, V_NAN,   16'd0,    16'hFFC6, 1'b0, 1'b0, 1'b0);
    preload(16'hFFF1);
    run_cmd(POP2,  3'd0, V_ZERO,  16'd0,    16'hFFFF, 1'b0, 1'b0, 1'b0);
    run_cmd(POP,   3'd0, V_ZERO,  16'd0,    16'hFFFF, 1'b0, 1'b1, 1'b0);
    preload(16'h3FFF);
    run_cmd(PUSH,  3'd0, V_ONE,   16'd0,    16'hFFFE, 1'b1, 1'b0, 1'b1);
    preload(16'h0000);
    run_cmd(FREE,  3'd3, V_ZERO,  16'd0,    16'h00C0, 1'b0, 1'b0, 1'b0);
    preload(16'h0000);
    run_cmd(WST,   3'd7, V_DENOR, 16'd0,    16'h8000, 1'b0, 1'b0, 1'b0);
    run_cmd(WST,   3'd0, V_UNNOR, 16'd0,    16'h8002, 1'b0, 1'b0, 1'b0);
    run_cmd(WST,   3'd1, V_ZERO,  16'd0,    16'h8006, 1'b0, 1'b0, 1'b0);
    run_cmd(WST,   3'd1, V_ONE,   16'd0,    16'h8002, 1'b0, 1'b0, 1'b1);
    run_cmd(LOAD,  3'd0, V_ZERO,  16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0);
    run_cmd(CLEAR, 3'd0, V_ZERO,  16'd0,    16'hFFFF, 1'b0, 1'b0, 1'b0);
    preload(16'hFFF7);
    run_cmd(POP2,  3'd0, V_ZERO,  16'd0,    16'hFFFF, 1'b0, 1'b1, 1'b0);
    run_cmd(LOAD,  3'd0, V_ZERO,  16'hA5F0, 16'hA5F0, 1'b0, 1'b0, 1'b0);
    run_cmd(NOP,   3'd0, V_ZERO,  16'd0,    16'hA5F0, 1'b0, 1'b0, 1'b0);

    // Reset while a PUSH sits in CLASSIFY: no strobe, outputs return to reset values.
    preload(16'hFFF0);
    cmd_valid = 1'b1; cmd_op = PUSH; cmd_index = 3'd0; cmd_value = V_ONE;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    exp_ready = 1'b0;
    reset     = 1'b1;
    @(posedge clk); #1;
    exp_ready = 1'b1;
    exp_data  = 16'hFFFF;
    reset     = 1'b0;
    @(negedge clk);
    chk("reset_ready", {15'd0, cmd_ready}, 16'd1);
    chk("reset_store", store, 16'hFFFF);
    repeat (2) begin
      @(posedge clk); #1;
    end
    run_cmd(PUSH,  3'd0, V_ZERO,  16'd0,    16'hFFFD, 1'b0, 1'b0, 1'b0);

    @(posedge clk); #1;
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
